operand_fetch: RTL and testbench

//  Issue stage that sits directly upstream of the ALU. Accepts decoded instructions
//   and reads both source operands from the register file. Forwards writeback data
//   and blocks issue on pending writes (scoreboard). Registers op/r0/r1/rd for the ALU.

---
 rtl/asm18_pkg.sv | 26 ++
 rtl/operand_fetch_if.sv | 42 ++++
 rtl/reg_file.sv | 36 +++
 rtl/operand_fetch.sv | 99 +++++++++
 tb/tb_operand_fetch.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/asm18_pkg.sv
// Shared widths, ALU opcodes and the issue payload for the asm18 pipeline.
package asm18_pkg;

    localparam int unsigned WORD_SIZE     = 18;
    localparam int unsigned REG_ADDR_BITS = 3;
    localparam int unsigned OP_BITS       = 4;
    localparam int unsigned NREGS         = 2 ** REG_ADDR_BITS;

    localparam logic [OP_BITS-1:0] ALU_OP_REG0 = OP_BITS'(0);
    localparam logic [OP_BITS-1:0] ALU_OP_REG1 = OP_BITS'(1);
    localparam logic [OP_BITS-1:0] ALU_OP_ADD  = OP_BITS'(2);

    // Operands handed to the ALU, plus the destination carried to writeback.
    typedef struct packed {
        logic [OP_BITS-1:0]       op;
        logic [WORD_SIZE-1:0]     r0;
        logic [WORD_SIZE-1:0]     r1;
        logic [REG_ADDR_BITS-1:0] rd;
    } issue_t;

    // One-hot mask for a register index.
    function automatic logic [NREGS-1:0] reg_mask(input logic [REG_ADDR_BITS-1:0] idx);
        return NREGS'(1) << idx;
    endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Issue-stage bus: decoded instruction in, ALU operands out, writeback port.
// master = surrounding pipeline (decode, ALU, writeback); slave = operand_fetch.
interface operand_fetch_if;
    import asm18_pkg::*;

    logic                     in_valid;
    logic                     in_ready;
    logic [OP_BITS-1:0]       in_op;
    logic [REG_ADDR_BITS-1:0] in_ra;
    logic [REG_ADDR_BITS-1:0] in_rb;
    logic [REG_ADDR_BITS-1:0] in_rd;
    logic                     in_use_imm;
    logic [WORD_SIZE-1:0]     in_imm;

    logic                     out_valid;
    logic                     out_ready;
    logic [OP_BITS-1:0]       out_op;
    logic [WORD_SIZE-1:0]     out_r0;
    logic [WORD_SIZE-1:0]     out_r1;
    logic [REG_ADDR_BITS-1:0] out_rd;

    logic                     wb_en;
    logic [REG_ADDR_BITS-1:0] wb_addr;
    logic [WORD_SIZE-1:0]     wb_data;

    modport master (
        output in_valid, in_op, in_ra, in_rb, in_rd, in_use_imm, in_imm,
        input  in_ready,
        input  out_valid, out_op, out_r0, out_r1, out_rd,
        output out_ready,
        output wb_en, wb_addr, wb_data
    );

    modport slave (
        input  in_valid, in_op, in_ra, in_rb, in_rd, in_use_imm, in_imm,
        output in_ready,
        output out_valid, out_op, out_r0, out_r1, out_rd,
        input  out_ready,
        input  wb_en, wb_addr, wb_data
    );

endinterface

// File: rtl/reg_file.sv
// Register file: NREGS x WORD_SIZE, two async read ports, one sync write port,
// synchronous active-low clear. Register 0 always reads 0 and ignores writes.
//  clk, rst_n        clock, synchronous active-low clear
//  ra_addr/ra_data   read port A
//  rb_addr/rb_data   read port B
//  we/wa/wd          write port
module reg_file
    import asm18_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [REG_ADDR_BITS-1:0] ra_addr,
    output logic [WORD_SIZE-1:0]     ra_data,
    input  logic [REG_ADDR_BITS-1:0] rb_addr,
    output logic [WORD_SIZE-1:0]     rb_data,
    input  logic                     we,
    input  logic [REG_ADDR_BITS-1:0] wa,
    input  logic [WORD_SIZE-1:0]     wd
);

    logic [WORD_SIZE-1:0] mem [NREGS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            mem[wa] <= wd;
        end
    end

    assign ra_data = (ra_addr == '0) ? '0 : mem[ra_addr];
    assign rb_data = (rb_addr == '0) ? '0 : mem[rb_addr];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch / issue stage ahead of the ALU. Reads sources with writeback
// bypass, blocks on pending writes via a scoreboard, and registers op/r0/r1/rd.
//  clk, rst_n  clock, synchronous active-low reset
//  bus         operand_fetch_if.slave: in_* instruction, out_* ALU operands,
//              wb_* register-file write port
module operand_fetch
    import asm18_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    operand_fetch_if.slave bus
);

    logic [WORD_SIZE-1:0] rf_a;
    logic [WORD_SIZE-1:0] rf_b;
    logic [NREGS-1:0]     pend;
    logic [NREGS-1:0]     pend_n;
    issue_t               out_q;
    issue_t               issue_d;
    logic                 out_valid_q;
    logic                 byp_a;
    logic                 byp_b;
    logic                 byp_d;
    logic                 hazard;
    logic                 issue;

    reg_file u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .ra_addr (bus.in_ra),
        .ra_data (rf_a),
        .rb_addr (bus.in_rb),
        .rb_data (rf_b),
        .we      (bus.wb_en),
        .wa      (bus.wb_addr),
        .wd      (bus.wb_data)
    );

    // Writeback landing this cycle on a source or destination index.
    assign byp_a = bus.wb_en && (bus.wb_addr == bus.in_ra);
    assign byp_b = bus.wb_en && (bus.wb_addr == bus.in_rb);
    assign byp_d = bus.wb_en && (bus.wb_addr == bus.in_rd);

    // Operand select and hazard detection; index 0 never hazards or bypasses.
    always_comb begin
        issue_d    = '0;
        issue_d.op = bus.in_op;
        issue_d.rd = bus.in_rd;
        hazard     = 1'b0;

        if (bus.in_ra != '0) begin
            issue_d.r0 = byp_a ? bus.wb_data : rf_a;
            if (pend[bus.in_ra] && !byp_a) hazard = 1'b1;
        end

        if (bus.in_use_imm) begin
            issue_d.r1 = bus.in_imm;
        end else if (bus.in_rb != '0) begin
            issue_d.r1 = byp_b ? bus.wb_data : rf_b;
            if (pend[bus.in_rb] && !byp_b) hazard = 1'b1;
        end

        if ((bus.in_rd != '0) && pend[bus.in_rd] && !byp_d) hazard = 1'b1;
    end

    assign bus.in_ready = (!out_valid_q || bus.out_ready) && !hazard;
    assign issue        = bus.in_valid && bus.in_ready;

    // Scoreboard update: a set on issue overrides a same-cycle writeback clear.
    always_comb begin
        pend_n = pend;
        if (bus.wb_en) pend_n = pend_n & ~reg_mask(bus.wb_addr);
        if (issue && (bus.in_rd != '0)) pend_n = pend_n | reg_mask(bus.in_rd);
    end

    // Output register and scoreboard state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            pend        <= '0;
        end else begin
            pend <= pend_n;
            if (issue) begin
                out_q       <= issue_d;
                out_valid_q <= 1'b1;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_op    = out_q.op;
    assign bus.out_r0    = out_q.r0;
    assign bus.out_r1    = out_q.r1;
    assign bus.out_rd    = out_q.rd;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios followed by random traffic, all
// checked each cycle against a register/pending-table model of the issue stage.
module tb_operand_fetch;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    operand_fetch_if bus ();

    operand_fetch dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [17:0] m_reg  [8];
    bit          m_pend [8];
    bit          m_ov;
    logic [3:0]  m_op;
    logic [17:0] m_r0;
    logic [17:0] m_r1;
    logic [2:0]  m_rd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 8; i++) begin
            m_reg[i]  = '0;
            m_pend[i] = 0;
        end
        m_ov = 0; m_op = '0; m_r0 = '0; m_r1 = '0; m_rd = '0;
    endfunction

    // Value a source index delivers this cycle, counting a same-cycle writeback.
    function automatic logic [17:0] src_val(input int s, input bit we, input int wa, input int wd);
        if (s == 0) return '0;
        if (we && wa == s) return 18'(wd);
        return m_reg[s];
    endfunction

    // A nonzero index is blocked if a write is outstanding and not landing now.
    function automatic bit blocked(input int s, input bit we, input int wa);
        return (s != 0) && m_pend[s] && !(we && wa == s);
    endfunction

    task automatic check_outputs(input string pfx);
        chk({pfx, "_out_valid"}, 32'(bus.out_valid), 32'(m_ov));
        chk({pfx, "_out_op"},    32'(bus.out_op),    32'(m_op));
        chk({pfx, "_out_r0"},    32'(bus.out_r0),    32'(m_r0));
        chk({pfx, "_out_r1"},    32'(bus.out_r1),    32'(m_r1));
        chk({pfx, "_out_rd"},    32'(bus.out_rd),    32'(m_rd));
    endtask

    // One clock: drive at the falling edge, check in_ready, advance the model
    // at the rising edge, check outputs at the next falling edge.
    task automatic step(input bit v, input int op, input int ra, input int rb, input int rd,
                        input bit ui, input int imm, input bit ordy,
                        input bit we, input int wa, input int wd, output bit issued);
        bit          rdy;
        logic [17:0] s0;
        logic [17:0] s1;
        bus.in_valid   = v;
        bus.in_op      = 4'(op);
        bus.in_ra      = 3'(ra);
        bus.in_rb      = 3'(rb);
        bus.in_rd      = 3'(rd);
        bus.in_use_imm = ui;
        bus.in_imm     = 18'(imm);
        bus.out_ready  = ordy;
        bus.wb_en      = we;
        bus.wb_addr    = 3'(wa);
        bus.wb_data    = 18'(wd);
        rdy = (!m_ov || ordy) &&
              !(blocked(ra, we, wa) || (!ui && blocked(rb, we, wa)) || blocked(rd, we, wa));
        s0 = src_val(ra, we, wa, wd);
        s1 = ui ? 18'(imm) : src_val(rb, we, wa, wd);
        #1;
        chk("in_ready", 32'(bus.in_ready), 32'(rdy));
        @(posedge clk);
        issued = v && rdy;
        if (we && wa != 0) m_reg[wa] = 18'(wd);
        if (we) m_pend[wa] = 0;
        if (issued) begin
            m_ov = 1; m_op = 4'(op); m_r0 = s0; m_r1 = s1; m_rd = 3'(rd);
            if (rd != 0) m_pend[rd] = 1;
        end else if (ordy) begin
            m_ov = 0;
        end
        @(negedge clk);
        check_outputs("step");
    endtask

    // Reset held against an instruction and a writeback that must both be ignored.
    task automatic apply_reset();
        rst_n          = 1'b0;
        bus.in_valid   = 1'b1;
        bus.in_op      = 4'd2;
        bus.in_ra      = 3'd3;
        bus.in_rb      = 3'd3;
        bus.in_rd      = 3'd3;
        bus.in_use_imm = 1'b0;
        bus.in_imm     = 18'h12345;
        bus.out_ready  = 1'b1;
        bus.wb_en      = 1'b1;
        bus.wb_addr    = 3'd3;
        bus.wb_data    = 18'h2AAAA;
        repeat (3) @(posedge clk);
        @(negedge clk);
        model_clear();
        check_outputs("rst");
        rst_n       = 1'b1;
        bus.in_valid = 1'b0;
        bus.wb_en   = 1'b0;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
    endtask

    bit iss;

    initial begin
        checks   = 0;
        failures = 0;
        model_clear();

        // 1: reset, then register 3 must still read 0
        apply_reset();
        step(1, 0, 3, 3, 0, 0, 0, 1, 0, 0, 0, iss);
        chk("t1_issue", 32'(iss), 32'd1);
        chk("t1_reg3_r0", 32'(bus.out_r0), 32'd0);
        chk("t1_reg3_r1", 32'(bus.out_r1), 32'd0);

        // 2: write r2=5, then ADD r2 + imm 7 -> rd 4
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 5, iss);
        step(1, 2, 2, 0, 4, 1, 7, 1, 0, 0, 0, iss);
        chk("t2_valid", 32'(bus.out_valid), 32'd1);
        chk("t2_r0", 32'(bus.out_r0), 32'd5);
        chk("t2_r1", 32'(bus.out_r1), 32'd7);
        chk("t2_op", 32'(bus.out_op), 32'd2);
        chk("t2_rd", 32'(bus.out_rd), 32'd4);

        // 3: RAW on r4 stalls until its writeback, which is bypassed on issue
        step(1, 1, 4, 0, 0, 0, 0, 1, 0, 0, 0, iss);
        chk("t3_stall_a", 32'(iss), 32'd0);
        step(1, 1, 4, 0, 0, 0, 0, 1, 0, 0, 0, iss);
        chk("t3_stall_b", 32'(iss), 32'd0);
        step(1, 1, 4, 0, 0, 0, 0, 1, 1, 4, 'h3FFFF, iss);
        chk("t3_issue", 32'(iss), 32'd1);
        chk("t3_r0", 32'(bus.out_r0), 32'h3FFFF);

        // 4: backpressure holds outputs, then back-to-back issue
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 2, 0, 6, 0, 0, 0, 0, 0, 0, iss);
            chk("t4_hold_issue", 32'(iss), 32'd0);
            chk("t4_hold_r0", 32'(bus.out_r0), 32'h3FFFF);
        end
        step(1, 1, 2, 0, 6, 0, 0, 1, 0, 0, 0, iss);
        chk("t4_issue0", 32'(iss), 32'd1);
        step(1, 2, 1, 2, 7, 0, 0, 1, 0, 0, 0, iss);
        chk("t4_issue1", 32'(iss), 32'd1);
        step(1, 3, 2, 2, 0, 0, 0, 1, 0, 0, 0, iss);
        chk("t4_issue2", 32'(iss), 32'd1);
        chk("t4_r1", 32'(bus.out_r1), 32'd5);

        // 5: writes to r0 are dropped; rd=0 never stalls
        step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 9, iss);
        chk("t5_issue0", 32'(iss), 32'd1);
        chk("t5_r0", 32'(bus.out_r0), 32'd0);
        chk("t5_r1", 32'(bus.out_r1), 32'd0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, iss);
        chk("t5_issue1", 32'(iss), 32'd1);
        chk("t5_r0_again", 32'(bus.out_r0), 32'd0);

        // 6: same-cycle writeback and re-issue to r5 leaves it pending
        step(1, 2, 0, 0, 5, 1, 1, 1, 0, 0, 0, iss);
        chk("t6_set", 32'(iss), 32'd1);
        step(1, 2, 0, 0, 5, 1, 3, 1, 1, 5, 'h155, iss);
        chk("t6_waw_issue", 32'(iss), 32'd1);
        step(1, 1, 5, 0, 0, 0, 0, 1, 0, 0, 0, iss);
        chk("t6_still_pending", 32'(iss), 32'd0);
        step(1, 1, 5, 0, 0, 0, 0, 1, 1, 5, 'hAB, iss);
        chk("t6_release", 32'(iss), 32'd1);
        chk("t6_r0", 32'(bus.out_r0), 32'hAB);

        // Random traffic with one reset mid-stream
        for (int n = 0; n < 1500; n++) begin
            if (n == 700) apply_reset();
            step(bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 7)), bit'($urandom_range(0, 1)),
                 int'($urandom & 32'h3FFFF), ($urandom_range(0, 3) != 0),
                 bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                 int'($urandom & 32'h3FFFF), iss);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
